// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 set-2 constants, decoder state type and named key codes.
package ps2_kbd_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Pause is E1 followed by seven more bytes that carry no key events.
  localparam int unsigned PAUSE_SKIP_LEN = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  localparam logic [8:0] KC_W     = 9'h01D;
  localparam logic [8:0] KC_S     = 9'h01B;
  localparam logic [8:0] KC_UP    = 9'h175;
  localparam logic [8:0] KC_DOWN  = 9'h172;
  localparam logic [8:0] KC_SPACE = 9'h029;

  function automatic logic [8:0] make_code(input logic ext, input logic [7:0] code);
    return {ext, code};
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder.sv
// Turns the PS/2 byte stream into make/break events; prefixes that stall
// longer than TIMEOUT cycles are abandoned.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT = 50_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       flush,
  output logic       evt_valid,
  output logic [8:0] evt_code,
  output logic       evt_break
);

  localparam int CW     = $clog2(TIMEOUT + 1);
  localparam int SKIP_W = $clog2(PAUSE_SKIP_LEN + 1);
  localparam logic [CW-1:0]     TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic [SKIP_W-1:0] SKIP_LOAD   = SKIP_W'(PAUSE_SKIP_LEN);

  ps2_state_e        r_state;
  ps2_state_e        w_state_eff;
  ps2_state_e        w_state_next;
  logic [CW-1:0]     r_idle_cnt;
  logic [SKIP_W-1:0] r_skip_cnt;
  logic [SKIP_W-1:0] w_skip_next;
  logic              w_expired;

  // A byte landing on the expiry cycle is decoded as if the prefix had already gone.
  assign w_expired   = (r_state != ST_IDLE) && (r_idle_cnt >= TIMEOUT_CNT);
  assign w_state_eff = w_expired ? ST_IDLE : r_state;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    w_state_next = w_state_eff;
    w_skip_next  = r_skip_cnt;
    evt_valid    = 1'b0;
    evt_code     = make_code(1'b0, rx_data);
    evt_break    = 1'b0;

    if (rx_valid && !flush) begin
      case (w_state_eff)
        ST_IDLE: begin
          if (rx_data == PS2_EXT) begin
            w_state_next = ST_EXT;
          end else if (rx_data == PS2_BRK) begin
            w_state_next = ST_BRK;
          end else if (rx_data == PS2_PAUSE) begin
            w_state_next = ST_SKIP;
            w_skip_next  = SKIP_LOAD;
          end else begin
            evt_valid = 1'b1;
          end
        end
        ST_EXT: begin
          if (rx_data == PS2_BRK) begin
            w_state_next = ST_EXT_BRK;
          end else if (rx_data != PS2_EXT) begin
            evt_valid    = 1'b1;
            evt_code     = make_code(1'b1, rx_data);
            w_state_next = ST_IDLE;
          end
        end
        ST_BRK: begin
          evt_valid    = 1'b1;
          evt_break    = 1'b1;
          w_state_next = ST_IDLE;
        end
        ST_EXT_BRK: begin
          evt_valid    = 1'b1;
          evt_break    = 1'b1;
          evt_code     = make_code(1'b1, rx_data);
          w_state_next = ST_IDLE;
        end
        ST_SKIP: begin
          w_skip_next = r_skip_cnt - SKIP_W'(1);
          if (r_skip_cnt <= SKIP_W'(1)) begin
            w_state_next = ST_IDLE;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    if (flush) begin
      w_state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_skip_cnt <= w_skip_next;
      if (rx_valid) begin
        r_idle_cnt <= '0;
      end else if (r_idle_cnt < TIMEOUT_CNT) begin
        r_idle_cnt <= r_idle_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks a parametrised table of PS/2 keys; each key is a held level or a
// one-cycle press pulse, updated the cycle after its completing byte.
module ps2_key_tracker
  import ps2_kbd_pkg::*;
#(
  parameter int                  N_KEYS     = 4,
  parameter logic [N_KEYS*9-1:0] KEY_CODES  = {KC_DOWN, KC_UP, KC_S, KC_W},
  parameter logic [N_KEYS-1:0]   PULSE_MASK = '0,
  parameter int                  TIMEOUT    = 50_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              flush,
  output logic [N_KEYS-1:0] keys,
  output logic              any_held,
  output logic [8:0]        last_code,
  output logic              last_break
);

  logic              w_evt_valid;
  logic [8:0]        w_evt_code;
  logic              w_evt_break;
  logic [N_KEYS-1:0] w_match;
  logic [N_KEYS-1:0] w_held_next;
  logic [N_KEYS-1:0] r_held;
  logic [N_KEYS-1:0] r_keys;
  logic [8:0]        r_last_code;
  logic              r_last_break;

  ps2_scancode_decoder #(
    .TIMEOUT (TIMEOUT)
  ) u_decoder (
    .clock     (clock),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .flush     (flush),
    .evt_valid (w_evt_valid),
    .evt_code  (w_evt_code),
    .evt_break (w_evt_break)
  );

  // Duplicate table entries all match, so every copy of a key follows the event.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_match[i] = (KEY_CODES[9*i +: 9] == w_evt_code);
    end
    w_held_next = r_held;
    if (w_evt_valid) begin
      w_held_next = w_evt_break ? (r_held & ~w_match) : (r_held | w_match);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_held       <= '0;
      r_keys       <= '0;
      r_last_code  <= '0;
      r_last_break <= 1'b0;
    end else if (flush) begin
      r_held <= '0;
      r_keys <= '0;
    end else begin
      r_held <= w_held_next;
      // Pulse keys fire only on a 0->1 of held, so typematic repeats stay quiet.
      r_keys <= (w_held_next & ~PULSE_MASK) | (w_held_next & ~r_held & PULSE_MASK);
      if (w_evt_valid) begin
        r_last_code  <= w_evt_code;
        r_last_break <= w_evt_break;
      end
    end
  end

  assign keys       = r_keys;
  assign any_held   = |r_held;
  assign last_code  = r_last_code;
  assign last_break = r_last_break;

endmodule
